fibonacci_lfsr_checker: RTL

FIBONACCI_LFSR_CHECKER -- requirements
Module: fibonacci_lfsr_checker

---
 rtl/fibonacci_lfsr_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fibonacci_lfsr_checker.sv
// Fibonacci LFSR sequence checker: locks onto a received LFSR word stream,
// flywheels its predictor while locked and counts/flags mismatched words.
module fibonacci_lfsr_checker #(
  parameter int                  BITWIDTH   = 64,
  parameter logic [BITWIDTH-1:0] TAPS       = 64'hD800000000000000,
  parameter int                  LOCK_COUNT = 4,
  parameter int                  LOSS_COUNT = 3
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] r_in,
  input  logic                clear_count,
  output logic                locked,
  output logic                err,
  output logic                lock_lost,
  output logic [15:0]         err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]  LOCK_N    = 8'(LOCK_COUNT);
  localparam logic [7:0]  LOSS_N    = 8'(LOSS_COUNT);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_t              state;
  logic [BITWIDTH-1:0] pred;
  logic [7:0]          mcnt;
  logic [7:0]          xcnt;

  logic [BITWIDTH-1:0] next_from_rx;
  logic [BITWIDTH-1:0] next_from_pred;
  logic                rx_match;
  logic                rx_zero;
  logic [7:0]          mcnt_inc;
  logic [7:0]          xcnt_inc;

  // Shift left, feedback (parity of tapped bits) enters at bit 0.
  function automatic logic [BITWIDTH-1:0] lfsr_next(input logic [BITWIDTH-1:0] s);
    return {s[BITWIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign next_from_rx   = lfsr_next(r_in);
  assign next_from_pred = lfsr_next(pred);
  assign rx_match       = (r_in == pred);
  assign rx_zero        = (r_in == '0);
  assign mcnt_inc       = mcnt + 8'd1;
  assign xcnt_inc       = xcnt + 8'd1;

  // NOTE: every register here is state, so all assignments are non-blocking;
  // a blocking '=' would let later statements see the new value mid-cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the predictor is a plain register (not memory), so it is reset
    // with everything else; mid-lock reset must leave no stale prediction.
    if (!nRST) begin
      state     <= HUNT;
      pred      <= '0;
      mcnt      <= '0;
      xcnt      <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      err       <= 1'b0;
      lock_lost <= 1'b0;

      if (in_valid) begin
        unique case (state)
          HUNT: begin
            if (!rx_zero) begin
              pred  <= next_from_rx;
              mcnt  <= '0;
              state <= VERIFY;
            end
          end

          VERIFY: begin
            if (rx_match) begin
              mcnt <= mcnt_inc;
              pred <= next_from_rx;
              if (mcnt_inc == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
                xcnt   <= '0;
              end
            end else begin
              mcnt <= '0;
              if (!rx_zero) begin
                pred <= next_from_rx;
              end else begin
                state <= HUNT;
              end
            end
          end

          LOCKED: begin
            // Flywheel: the received word never reseeds the predictor here.
            pred <= next_from_pred;
            if (rx_match) begin
              xcnt <= '0;
            end else begin
              err  <= 1'b1;
              xcnt <= xcnt_inc;
              if (err_count != COUNT_MAX) begin
                err_count <= err_count + 16'd1;
              end
              if (xcnt_inc == LOSS_N) begin
                state     <= HUNT;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                xcnt      <= '0;
              end
            end
          end

          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end

      // Clear wins over a same-cycle increment.
      if (clear_count) begin
        err_count <= '0;
      end
    end
  end

endmodule
